// File: rtl/bus_arbiter16_pkg.sv
// rtl/bus_arbiter16_pkg.sv - shared constants, state encoding and helpers for the 16-way bus arbiter
package bus_arbiter16_pkg;

    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;
    // Wide enough for MAX_HOLD-1 over the whole legal MAX_HOLD range (1..255)
    localparam int CNT_W   = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // One-hot vector with only bit idx set
    function automatic logic [NUM_REQ-1:0] onehot_of(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/bus_arbiter16_rr_priority_pick16.sv
// rtl/bus_arbiter16_rr_priority_pick16.sv - combinational round-robin pick: first set mask bit at or above start, wrapping 15 -> 0
module rr_priority_pick16
    import bus_arbiter16_pkg::*;
(
    input  logic [NUM_REQ-1:0] mask,
    input  logic [SEL_W-1:0]   start,
    output logic [SEL_W-1:0]   index,
    output logic               found
);

    logic [SEL_W-1:0] cand;

    // Walk the sixteen positions starting at start; the first set bit wins
    always_comb begin
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = start + SEL_W'(i);
            if (!found && mask[cand]) begin
                index = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter16.sv
// rtl/bus_arbiter16.sv - 16-requester round-robin bus arbiter with hold-time preemption and lock
module bus_arbiter16
    import bus_arbiter16_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] request,
    input  logic               lock,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   select,
    output logic               bus_valid,
    output logic               handoff
);

    // Counter value at which the owner becomes preemptible
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   select_q, select_d;
    logic               handoff_q, handoff_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] pick_mask;
    logic [SEL_W-1:0]   pick_start;
    logic [SEL_W-1:0]   pick_index;
    logic               pick_found;

    logic               owner_req;
    logic               hold_done;
    logic               take_new;
    logic               owner_release;

    assign owner_req = request[select_q];
    assign hold_done = (cnt_q == HOLD_LAST);

    // Idle searches from the pointer; busy searches past the owner and never re-picks it
    always_comb begin
        pick_mask  = request;
        pick_start = ptr_q;
        if (state_q == ST_BUSY) begin
            pick_mask  = request & ~grant_q;
            pick_start = select_q + SEL_W'(1);
        end
    end

    rr_priority_pick16 u_pick (
        .mask  (pick_mask),
        .start (pick_start),
        .index (pick_index),
        .found (pick_found)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: release has priority over expiry; lock only blocks expiry-driven preemption
    always_comb begin
        state_d       = state_q;
        take_new      = 1'b0;
        owner_release = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d  = ST_BUSY;
                    take_new = 1'b1;
                end
            end
            ST_BUSY: begin
                if (!owner_req) begin
                    owner_release = 1'b1;
                    if (pick_found) begin
                        take_new = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (hold_done && !lock && pick_found) begin
                    take_new = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and bookkeeping: new owner loads grant/select and restarts the hold count
    always_comb begin
        grant_d   = grant_q;
        select_d  = select_q;
        handoff_d = 1'b0;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        if (take_new) begin
            grant_d   = onehot_of(pick_index);
            select_d  = pick_index;
            handoff_d = 1'b1;
            cnt_d     = '0;
        end else if (state_q == ST_BUSY && state_d == ST_IDLE) begin
            grant_d = '0;
            cnt_d   = '0;
        end else if (state_q == ST_BUSY && !hold_done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (state_q == ST_BUSY && (owner_release || take_new)) begin
            ptr_d = select_q + SEL_W'(1);
        end
    end

    // Registered outputs and arbitration bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q   <= '0;
            select_q  <= '0;
            handoff_q <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            grant_q   <= grant_d;
            select_q  <= select_d;
            handoff_q <= handoff_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign grant     = grant_q;
    assign select    = select_q;
    assign bus_valid = (state_q == ST_BUSY);
    assign handoff   = handoff_q;

endmodule

// File: tb/tb_bus_arbiter16.sv
// tb/tb_bus_arbiter16.sv - scoreboard bench for bus_arbiter16 with directed hand-computed vectors
module tb_bus_arbiter16;

    logic        clk;
    logic        rst;
    logic [15:0] request;
    logic        lock;
    logic [15:0] grant;
    logic [3:0]  select;
    logic        bus_valid;
    logic        handoff;

    typedef struct {
        logic [15:0] grant;
        logic [3:0]  sel;
        logic        valid;
        logic        ho;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_bad;

    bus_arbiter16 #(.MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .request   (request),
        .lock      (lock),
        .grant     (grant),
        .select    (select),
        .bus_valid (bus_valid),
        .handoff   (handoff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input exp_t e);
        n_vec++;
        if (grant !== e.grant || select !== e.sel || bus_valid !== e.valid || handoff !== e.ho) begin
            n_bad++;
            $display("FAIL %s: got grant=%h sel=%0d valid=%0b handoff=%0b, expected grant=%h sel=%0d valid=%0b handoff=%0b",
                     e.name, grant, select, bus_valid, handoff, e.grant, e.sel, e.valid, e.ho);
        end
    endtask

    // Monitor: outputs settle just after each rising edge; pop one expectation per edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                compare(exp_q.pop_front());
            end
        end
    end

    // Drive one cycle of inputs at the falling edge and queue the outputs expected after the next rise
    task automatic step(input logic r, input logic [15:0] req, input logic lk,
                        input logic ev, input logic [3:0] es, input logic eh, input string nm);
        exp_t e;
        @(negedge clk);
        rst     = r;
        request = req;
        lock    = lk;
        e.grant = ev ? (16'h0001 << es) : 16'h0000;
        e.sel   = es;
        e.valid = ev;
        e.ho    = eh;
        e.name  = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, pending=%0d required=0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t z;
        n_vec   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        request = 16'h0000;
        lock    = 1'b0;

        step(1, 16'h0000, 0, 0, 0, 0, "reset_state");
        step(1, 16'hffff, 0, 0, 0, 0, "reset_blocks_grant");

        // First grant one cycle after request, then 0/15 alternate every 8 cycles
        step(0, 16'h0001, 0, 1, 0, 1, "first_grant_0");
        for (int i = 0; i < 7; i++) step(0, 16'h8001, 0, 1, 0, 0, "hold_0");
        step(0, 16'h8001, 0, 1, 15, 1, "preempt_to_15");
        for (int i = 0; i < 7; i++) step(0, 16'h8001, 0, 1, 15, 0, "hold_15");
        step(0, 16'h8001, 0, 1, 0, 1, "preempt_back_0");
        step(0, 16'h8001, 0, 1, 0, 0, "hold_0_again");
        step(0, 16'h0000, 0, 0, 0, 0, "release_to_idle");

        // Owner 3 releases with 5 and 1 waiting: 5 wins from pointer 4, no dead cycle
        step(0, 16'h0008, 0, 1, 3, 1, "grant_3");
        step(0, 16'h0022, 0, 1, 5, 1, "release_handoff_5");
        step(0, 16'h0020, 0, 1, 5, 0, "hold_5");
        step(0, 16'h0000, 0, 0, 5, 0, "idle_select_holds_5");

        // Lock keeps owner 2 past expiry; dropping lock preempts to 9
        step(0, 16'h0004, 0, 1, 2, 1, "grant_2");
        for (int i = 0; i < 20; i++) step(0, 16'h0204, 1, 1, 2, 0, "locked_2");
        step(0, 16'h0204, 0, 1, 9, 1, "unlock_preempt_9");
        step(0, 16'h0200, 0, 1, 9, 0, "hold_9");
        step(0, 16'h0000, 0, 0, 9, 0, "idle_after_9");
        step(0, 16'h0000, 0, 0, 9, 0, "idle_no_request");

        // Sole requester keeps the bus indefinitely with a single handoff
        step(0, 16'h0010, 0, 1, 4, 1, "grant_4");
        for (int i = 0; i < 29; i++) step(0, 16'h0010, 0, 1, 4, 0, "sole_owner_4");
        step(0, 16'h0000, 0, 0, 4, 0, "idle_after_4");

        // Reset in the middle of owner 7's tenure
        step(0, 16'h0080, 0, 1, 7, 1, "grant_7");
        step(0, 16'h0080, 0, 1, 7, 0, "hold_7");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        z.grant = 16'h0000;
        z.sel   = 4'd0;
        z.valid = 1'b0;
        z.ho    = 1'b0;
        z.name  = "async_reset";
        compare(z);
        step(1, 16'h0088, 0, 0, 0, 0, "held_in_reset");
        step(0, 16'h0088, 0, 1, 3, 1, "post_reset_grant_3");
        step(0, 16'h0080, 0, 1, 7, 1, "release_handoff_7");
        step(0, 16'h0000, 0, 0, 7, 0, "idle_after_7");

        // Pointer is 8: search wraps past 15 to reach 0
        step(0, 16'h0001, 0, 1, 0, 1, "wrap_grant_0");
        step(0, 16'h0041, 0, 1, 0, 0, "wrap_hold_0");
        step(0, 16'h0040, 0, 1, 6, 1, "release_handoff_6");

        @(posedge clk);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter16.md
BUS_ARBITER16 -- requirements
Module: bus_arbiter16

Interface
REQ-001 Parameter MAX_HOLD, default 8, meaning maximum consecutive owned cycles before preemption when others wait (legal range 1..255).
REQ-002 Clock  input  1  sole clock, all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Request  input  16  bit i high = requester i wants the shared 16-bit bus.
REQ-005 Lock  input  1  high = current owner inhibits preemption (ignored when no owner).
REQ-006 Grant  output  16  one-hot owner indication, all-zero when bus idle.
REQ-007 Select  output  4  binary index of owner, drives Select of the 16-to-1 bus mux.
REQ-008 BusValid  output  1  high while an owner exists (mux output meaningful).
REQ-009 Handoff  output  1  one-cycle pulse in the first cycle of any new ownership.

Function
REQ-010 The block SHALL implement states IDLE and BUSY; BusValid SHALL equal (state == BUSY).
REQ-011 All outputs SHALL be registered; Request to Grant latency SHALL be exactly 1 cycle from IDLE.
REQ-012 IDLE -> BUSY SHALL occur when Request != 0; the winner is the first set bit searching upward from pointer, wrapping 15 -> 0.
REQ-013 Grant SHALL be one-hot with Grant[Select] = 1 whenever BusValid = 1; Select SHALL hold its last value in IDLE.
REQ-014 In BUSY the owner SHALL keep the bus while Request[owner] = 1, except when preempted.
REQ-015 Release: when Request[owner] = 0 at an edge, pointer SHALL become owner+1 (mod 16); if any other bit is set, the new winner SHALL be granted that same edge (zero dead cycles), else the block SHALL go to IDLE.
REQ-016 Hold counter SHALL reset to 0 on each new ownership and increment per BUSY cycle, saturating at MAX_HOLD-1.
REQ-017 Preemption: when counter == MAX_HOLD-1, Lock = 0, and (Request & ~Grant) != 0, ownership SHALL pass at that edge to the winner searched from owner+1, excluding the owner.
REQ-018 If only the owner requests, the counter SHALL saturate and ownership SHALL continue; no Handoff pulse.
REQ-019 Lock high SHALL hold the counter at saturation without preempting; preemption SHALL occur on the first edge Lock is sampled low with waiters present.
REQ-020 Handoff SHALL pulse on IDLE -> BUSY, on release-handoff, and on preemption; never otherwise.
REQ-021 Simultaneous release and expiry SHALL be treated as release (REQ-015).
REQ-022 A requester deasserting before being granted SHALL not be granted; Request is level-sensitive, no queuing.

Reset
REQ-023 Reset high SHALL immediately force: state IDLE, Grant = 0, Select = 0, BusValid = 0, Handoff = 0, pointer = 0, counter = 0.
REQ-024 Reset asserted mid-ownership SHALL drop the grant without completing any handoff; first grant after release follows REQ-012 from pointer 0.

Structure
REQ-025 A shared package SHALL hold NUM_REQ = 16, SEL_W = 4, the state encoding (IDLE, BUSY) and the counter width constant.
REQ-026 The round-robin search SHALL be one combinational sub-module, rr_priority_pick16 (inputs: 16-bit mask, 4-bit start; outputs: 4-bit index, found flag).
REQ-027 Select SHALL connect directly to the 16-to-1 bus mux; the arbiter SHALL not route data itself.

Verification
REQ-028 Reset, then Request = 0x0001 -> next cycle Grant = 0x0001, Select = 0, BusValid = 1, Handoff = 1 for one cycle.
REQ-029 Request = 0x8001 held, MAX_HOLD = 8, Lock = 0 -> owner 0 for 8 cycles, then Select = 15 for 8 cycles, then back to 0; Handoff pulses at each switch.
REQ-030 Owner 3 drops Request while Request[5] and Request[1] set -> Grant = 0x0020 on the next cycle, no idle cycle between.
REQ-031 Owner 2 with Lock = 1 and Request[9] set for 20 cycles -> Select stays 2; Lock drops -> Select = 9 on next edge.
REQ-032 Request = 0x0010 only, held 30 cycles -> Grant constant 0x0010, Handoff pulses once.
REQ-033 Reset asserted while owner 7 busy -> outputs zero asynchronously; after release with Request = 0x0088 -> Select = 3.
